// File: rtl/fir_readout_ctrl.sv
// Readout sequencer for fir_top: restarts the core, waits for done, streams the result registers.
// Build option: define FIR_CTRL_CONTINUOUS_EN for free-running frames after a single start.
module fir_readout_ctrl #(
    parameter int unsigned RESULT_COUNT = 10,
    parameter int unsigned ADDR_W       = 5,
    parameter int unsigned DATA_W       = 17,
    parameter int unsigned RD_LAT       = 1,
    parameter int unsigned RST_CYC      = 4,
    parameter int unsigned TIMEOUT      = 4096
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    output logic              o_fir_reset,
    input  logic              i_fir_done,
    output logic [ADDR_W-1:0] o_fir_addr,
    input  logic [DATA_W-1:0] i_fir_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_out_data,
    output logic [ADDR_W-1:0] o_out_index,
    output logic              o_busy,
    output logic              o_frame_done,
    output logic              o_timeout_err
);

    // One counter serves the reset hold, the done timeout and the read latency.
    localparam int unsigned CNT_MAX_A = (TIMEOUT > RST_CYC) ? TIMEOUT : RST_CYC;
    localparam int unsigned CNT_MAX   = (CNT_MAX_A > RD_LAT) ? CNT_MAX_A : RD_LAT;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]  RST_LAST = CNT_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0]  TO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  LAT_LAST = CNT_W'(RD_LAT - 1);
    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(RESULT_COUNT - 1);

    typedef enum logic [2:0] {
        StIdle, StRstFir, StWaitDone, StAddr, StCapture, StOutput, StFinish
    } state_t;

    state_t             r_state, w_state;
    logic [CNT_W-1:0]   r_cnt, w_cnt;
    logic [ADDR_W-1:0]  r_idx, w_idx;
    logic               r_fir_reset, w_fir_reset;
    logic [ADDR_W-1:0]  r_fir_addr, w_fir_addr;
    logic               r_out_valid, w_out_valid;
    logic [DATA_W-1:0]  r_out_data, w_out_data;
    logic [ADDR_W-1:0]  r_out_index, w_out_index;
    logic               r_busy, w_busy;
    logic               r_frame_done, w_frame_done;
    logic               r_timeout_err, w_timeout_err;

    always_comb begin
        w_state       = r_state;
        w_cnt         = r_cnt;
        w_idx         = r_idx;
        w_fir_reset   = r_fir_reset;
        w_fir_addr    = r_fir_addr;
        w_out_valid   = r_out_valid;
        w_out_data    = r_out_data;
        w_out_index   = r_out_index;
        w_frame_done  = 1'b0;
        w_timeout_err = r_timeout_err;
        case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state       = StRstFir;
                    w_timeout_err = 1'b0;
                    w_fir_reset   = 1'b1;
                    w_cnt         = '0;
                end
            end
            StRstFir: begin
                if (r_cnt == RST_LAST) begin
                    w_state     = StWaitDone;
                    w_fir_reset = 1'b0;
                    w_cnt       = '0;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            StWaitDone: begin
                if (i_fir_done) begin
                    w_state    = StAddr;
                    w_idx      = '0;
                    w_fir_addr = '0;
                    w_cnt      = '0;
                end else if (r_cnt == TO_LAST) begin
                    w_state       = StIdle;
                    w_timeout_err = 1'b1;
                    w_fir_reset   = 1'b1;
                    w_cnt         = '0;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            StAddr: begin
                if (r_cnt == LAT_LAST) begin
                    w_state = StCapture;
                    w_cnt   = '0;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            StCapture: begin
                w_out_data  = i_fir_data;
                w_out_index = r_idx;
                w_out_valid = 1'b1;
                w_state     = StOutput;
            end
            StOutput: begin
                if (i_out_ready) begin
                    w_out_valid = 1'b0;
                    if (r_idx == IDX_LAST) begin
                        w_state      = StFinish;
                        w_frame_done = 1'b1;
                    end else begin
                        w_idx      = r_idx + 1'b1;
                        w_fir_addr = r_idx + 1'b1;
                        w_cnt      = '0;
                        w_state    = StAddr;
                    end
                end
            end
            StFinish: begin
                w_fir_reset = 1'b1;
                w_cnt       = '0;
`ifdef FIR_CTRL_CONTINUOUS_EN
                w_state     = StRstFir;
`else
                w_state     = StIdle;
`endif
            end
            default: w_state = StIdle;
        endcase
        w_busy = (w_state != StIdle);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= StIdle;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_fir_reset   <= 1'b1;
            r_fir_addr    <= '0;
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_out_index   <= '0;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_cnt         <= w_cnt;
            r_idx         <= w_idx;
            r_fir_reset   <= w_fir_reset;
            r_fir_addr    <= w_fir_addr;
            r_out_valid   <= w_out_valid;
            r_out_data    <= w_out_data;
            r_out_index   <= w_out_index;
            r_busy        <= w_busy;
            r_frame_done  <= w_frame_done;
            r_timeout_err <= w_timeout_err;
        end
    end

    assign o_fir_reset   = r_fir_reset;
    assign o_fir_addr    = r_fir_addr;
    assign o_out_valid   = r_out_valid;
    assign o_out_data    = r_out_data;
    assign o_out_index   = r_out_index;
    assign o_busy        = r_busy;
    assign o_frame_done  = r_frame_done;
    assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_fir_readout_ctrl.sv
// Self-checking bench for fir_readout_ctrl with a behavioural fir_top model and a word scoreboard.
// Exercises the FIR_CTRL_CONTINUOUS_EN build when that macro is defined.
module tb_fir_readout_ctrl;

    localparam int RESULT_COUNT = 10;
    localparam int ADDR_W       = 5;
    localparam int DATA_W       = 17;
    localparam int RD_LAT       = 1;
    localparam int RST_CYC      = 4;
    localparam int TIMEOUT      = 64;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              fir_reset;
    logic              fir_done;
    logic [ADDR_W-1:0] fir_addr;
    logic [DATA_W-1:0] fir_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_index;
    logic              busy;
    logic              frame_done;
    logic              timeout_err;

    fir_readout_ctrl #(
        .RESULT_COUNT(RESULT_COUNT),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .RD_LAT      (RD_LAT),
        .RST_CYC     (RST_CYC),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .o_fir_reset  (fir_reset),
        .i_fir_done   (fir_done),
        .o_fir_addr   (fir_addr),
        .i_fir_data   (fir_data),
        .o_out_valid  (out_valid),
        .i_out_ready  (out_ready),
        .o_out_data   (out_data),
        .o_out_index  (out_index),
        .o_busy       (busy),
        .o_frame_done (frame_done),
        .o_timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // fir_top model: done is cleared while held in reset, rises m_d cycles after release.
    logic [DATA_W-1:0] mem [0:31];
    int m_cnt;
    int m_d;
    bit m_done_en;
    bit m_stale;
    bit m_pulse;

    always @(posedge clk) begin
        if (fir_reset) m_cnt <= 0;
        else if (m_cnt < 100000) m_cnt <= m_cnt + 1;
        fir_data <= mem[fir_addr];
    end

    assign fir_done = fir_reset ? m_stale
                                : (m_done_en && (m_pulse ? (m_cnt == m_d) : (m_cnt >= m_d)));

    // Scoreboard
    typedef struct {
        logic [ADDR_W-1:0] idx;
        logic [DATA_W-1:0] data;
    } word_t;

    word_t exp_q[$];
    int n_checks, n_fail;
    int cycle;
    int n_frames, n_pops, rst_run;
    bit prev_stall, valid_seen;
    logic [DATA_W-1:0] prev_data;
    logic [ADDR_W-1:0] prev_index;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic push_frame();
        word_t w;
        for (int i = 0; i < RESULT_COUNT; i++) begin
            w.idx  = ADDR_W'(i);
            w.data = mem[i];
            exp_q.push_back(w);
        end
    endtask

    // Runs at the falling edge: outputs are settled, inputs hold what the next rising edge sees.
    task automatic check_now();
        word_t w;
        if (prev_stall) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, prev_data);
            chk("stall_index", out_index, prev_index);
        end
        if (out_valid) valid_seen = 1;
        if (out_valid && out_ready) begin
            chk("word_pending", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                w = exp_q.pop_front();
                chk("word_index", out_index, w.idx);
                chk("word_data", out_data, w.data);
                n_pops++;
            end
        end
        if (frame_done) begin
            chk("frame_done_all_words", exp_q.size(), 0);
            n_frames++;
`ifdef FIR_CTRL_CONTINUOUS_EN
            if (m_done_en) push_frame();
`endif
        end
        if (busy && fir_reset) begin
            rst_run++;
        end else if (rst_run != 0) begin
            chk("fir_reset_width", rst_run, RST_CYC);
            rst_run = 0;
        end
        if (start && !busy && m_done_en) push_frame();
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_index = out_index;
    endtask

    task automatic cyc();
        check_now();
        @(posedge clk);
        @(negedge clk);
        cycle++;
    endtask

    task automatic run_frame(input int d, input int pct, input int exp_lat, input bit spam,
                             input string tag);
        int t0, first, fd0;
        bit ended;
        m_d = d;
        fd0 = n_frames;
        first = -1;
        ended = 0;
        start = 1;
        t0 = cycle;
        cyc();
        start = 0;
        for (int k = 0; k < 3000; k++) begin
            out_ready = ($urandom_range(99) < pct);
            start = spam && out_valid && ($urandom_range(1) == 1);
            cyc();
            if (out_valid && first < 0) first = cycle - t0;
            if (!busy) begin
                ended = 1;
                break;
            end
        end
        start = 0;
        chk({tag, " frame_end"}, ended, 1);
        chk({tag, " first_valid_lat"}, first, exp_lat);
        chk({tag, " frame_done_count"}, n_frames - fd0, 1);
        chk({tag, " words_left"}, exp_q.size(), 0);
        chk({tag, " timeout_err"}, timeout_err, 0);
    endtask

    typedef struct {
        int d;
        int pct;
        int salt;
        int exp_lat;
        bit spam;
        bit stale;
    } vec_t;

    vec_t tbl[4];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, tl, fd0;
        bit ended, busy_ok;

        tbl[0] = '{d: 20, pct: 100, salt: 0,    exp_lat: 28, spam: 0, stale: 0};
        tbl[1] = '{d: 20, pct: 30,  salt: 0,    exp_lat: 28, spam: 0, stale: 0};
        tbl[2] = '{d: 0,  pct: 60,  salt: 1000, exp_lat: 8,  spam: 1, stale: 0};
        tbl[3] = '{d: 10, pct: 50,  salt: 5,    exp_lat: 18, spam: 1, stale: 1};

        clk = 0;
        rst_n = 1;
        start = 0;
        out_ready = 0;
        m_d = 0;
        m_done_en = 1;
        m_stale = 0;
        m_pulse = 0;
        for (int i = 0; i < 32; i++) mem[i] = '0;
        #1 rst_n = 0;
        repeat (3) @(negedge clk);
        chk("rst fir_reset", fir_reset, 1);
        chk("rst fir_addr", fir_addr, 0);
        chk("rst out_valid", out_valid, 0);
        chk("rst out_data", out_data, 0);
        chk("rst out_index", out_index, 0);
        chk("rst busy", busy, 0);
        chk("rst frame_done", frame_done, 0);
        chk("rst timeout_err", timeout_err, 0);
        rst_n = 1;
        cyc();
        chk("idle fir_reset", fir_reset, 1);

`ifndef FIR_CTRL_CONTINUOUS_EN
        foreach (tbl[v]) begin
            for (int i = 0; i < 32; i++) mem[i] = DATA_W'(i * 3 + tbl[v].salt);
            m_stale = tbl[v].stale;
            cyc();
            if (tbl[v].stale) chk("stale done present", fir_done, 1);
            run_frame(tbl[v].d, tbl[v].pct, tbl[v].exp_lat, tbl[v].spam, $sformatf("vec%0d", v));
            m_stale = 0;
            repeat (20) cyc();
            chk($sformatf("vec%0d no extra frame", v), busy, 0);
        end

        for (int f = 0; f < 4; f++) begin
            int d;
            for (int i = 0; i < 32; i++) mem[i] = DATA_W'($urandom);
            d = $urandom_range(0, 25);
            m_pulse = f[0];
            run_frame(d, $urandom_range(20, 100), 1 + RST_CYC + 1 + d + RD_LAT + 1, f[1],
                      $sformatf("rand%0d", f));
            m_pulse = 0;
            cyc();
        end
`endif

        // Done never comes: expect a timeout and no words.
        m_done_en = 0;
        out_ready = 1;
        valid_seen = 0;
        tl = -1;
        ended = 0;
        start = 1;
        t0 = cycle;
        cyc();
        start = 0;
        for (int k = 0; k < 300; k++) begin
            cyc();
            if (timeout_err && tl < 0) tl = cycle - t0;
            if (!busy) begin
                ended = 1;
                break;
            end
        end
        chk("timeout ended", ended, 1);
        chk("timeout_err cycle", tl, 1 + RST_CYC + TIMEOUT);
        chk("timeout idle cycle", cycle - t0, 1 + RST_CYC + TIMEOUT);
        chk("timeout no words", valid_seen, 0);
        repeat (3) cyc();
        chk("timeout sticky", timeout_err, 1);

        m_done_en = 1;
        m_d = 3;
        for (int i = 0; i < 32; i++) mem[i] = DATA_W'($urandom);
        start = 1;
        cyc();
        start = 0;
        cyc();
        chk("timeout cleared by start", timeout_err, 0);

`ifdef FIR_CTRL_CONTINUOUS_EN
        fd0 = n_frames;
        busy_ok = 1;
        for (int k = 0; k < 3000; k++) begin
            out_ready = ($urandom_range(99) < 70);
            start = ($urandom_range(9) == 0);
            cyc();
            if (!busy) busy_ok = 0;
            if (n_frames >= fd0 + 3) break;
        end
        start = 0;
        chk("cont three frames", n_frames - fd0 >= 3, 1);
        chk("cont busy held", busy_ok, 1);
`else
        ended = 0;
        for (int k = 0; k < 3000; k++) begin
            out_ready = ($urandom_range(99) < 80);
            cyc();
            if (!busy) begin
                ended = 1;
                break;
            end
        end
        chk("post-timeout frame ended", ended, 1);
        chk("post-timeout words", exp_q.size(), 0);
`endif

        // Asynchronous reset while a word is held in OUTPUT part-way through a frame.
        out_ready = 1;
        if (!busy) begin
            start = 1;
            cyc();
            start = 0;
        end
        fd0 = n_pops;
        for (int k = 0; k < 500 && n_pops < fd0 + 3; k++) cyc();
        out_ready = 0;
        ended = 0;
        for (int k = 0; k < 100; k++) begin
            if (out_valid) begin
                ended = 1;
                break;
            end
            cyc();
        end
        chk("reset test reached output", ended, 1);
        chk("reset test fir_addr busy", fir_addr != 0, 1);
        #2 rst_n = 0;
        #1;
        chk("async rst out_valid", out_valid, 0);
        chk("async rst busy", busy, 0);
        chk("async rst fir_reset", fir_reset, 1);
        chk("async rst fir_addr", fir_addr, 0);
        chk("async rst out_index", out_index, 0);
        exp_q.delete();
        rst_run = 0;
        prev_stall = 0;
        @(negedge clk);
        cycle++;
        rst_n = 1;
        out_ready = 1;
        valid_seen = 0;
        fd0 = n_frames;
        repeat (30) cyc();
        chk("after reset no words", valid_seen, 0);
        chk("after reset no frame_done", n_frames - fd0, 0);

`ifndef FIR_CTRL_CONTINUOUS_EN
        for (int i = 0; i < 32; i++) mem[i] = DATA_W'(i * 3);
        run_frame(20, 100, 28, 0, "recover");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
